// File: rtl/vga_sync_gen_pkg.sv
// 640x480@60 Hz timing constants and the per-axis region encoding shared by
// the VGA sync generator and its axis counters.
package vga_timing_pkg;

  localparam int CW = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } region_e;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle between the sync generator (master) and the renderer
// (slave); the renderer side also supplies the divider's pixel_rate level.
interface vga_sync_gen_if #(
  parameter int CW = 10
);
  logic          pixel_rate;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_tick;
  logic          frame_tick;

  modport master (
    input  pixel_rate,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
  );

  modport slave (
    output pixel_rate,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen_sync_axis_counter.sv
// One timing axis: wrap-around counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// Flags are decoded from the next state so they line up with the count shown.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = 1'b0,
  parameter int   CW     = vga_timing_pkg::CW
) (
  input  logic          CLK_NX,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          active,
  output logic          wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FRONT_START = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] BACK_START  = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_d;
  region_e       state_q, state_d;
  logic          sync_q, sync_d;
  logic          active_q, active_d;

  assign wrap = en && (count_q == LAST);

  // State register: reset parks the axis on its last count, inside BACK.
  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      count_q  <= LAST;
      state_q  <= ST_BACK;
      sync_q   <= ~POL;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      state_q  <= state_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  // Next-state: the region changes on the tick whose new count enters the next region.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      case (state_q)
        ST_ACTIVE: if (count_d == FRONT_START) state_d = ST_FRONT;
        ST_FRONT:  if (count_d == SYNC_START)  state_d = ST_SYNC;
        ST_SYNC:   if (count_d == BACK_START)  state_d = ST_BACK;
        ST_BACK:   if (count_d == '0)          state_d = ST_ACTIVE;
        default:   state_d = ST_BACK;
      endcase
    end
  end

  always_comb begin
    sync_d   = (state_d == ST_SYNC) ? POL : ~POL;
    active_d = (state_d == ST_ACTIVE);
  end

  assign count  = count_q;
  assign sync   = sync_q;
  assign active = active_q;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing generator on CLK_NX, advanced by rising edges of the
// divider's pixel_rate level; emits sync, blanking, coordinates and tick pulses.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = vga_timing_pkg::CW
) (
  input  logic           CLK_NX,
  input  logic           reset,
  vga_sync_gen_if.master vif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 2**CW || V_TOT > 2**CW) begin : g_cw_check
    $error("vga_sync_gen: CW too narrow for the configured line/frame totals");
  end

  logic          pix_q, pix_d;
  logic          line_tick_q, line_tick_d;
  logic          frame_tick_q, frame_tick_d;
  logic          tick;
  logic [CW-1:0] h_count, v_count;
  logic          h_sync, v_sync, h_active, v_active, h_wrap, v_wrap;

  // pix_q resets high so a pixel_rate already high at release is not a tick.
  assign tick = vif.pixel_rate & ~pix_q;

  sync_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(SYNC_POL), .CW(CW)
  ) u_h (
    .CLK_NX(CLK_NX), .reset(reset), .en(tick),
    .count(h_count), .sync(h_sync), .active(h_active), .wrap(h_wrap)
  );

  sync_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(SYNC_POL), .CW(CW)
  ) u_v (
    .CLK_NX(CLK_NX), .reset(reset), .en(h_wrap),
    .count(v_count), .sync(v_sync), .active(v_active), .wrap(v_wrap)
  );

  always_comb begin
    pix_d        = vif.pixel_rate;
    line_tick_d  = h_wrap;
    frame_tick_d = v_wrap;
  end

  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      pix_q        <= 1'b1;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_q        <= pix_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vif.pixel_x    = h_count;
  assign vif.pixel_y    = v_count;
  assign vif.hsync      = h_sync;
  assign vif.vsync      = v_sync;
  assign vif.video_on   = h_active & v_active;
  assign vif.line_tick  = line_tick_q;
  assign vif.frame_tick = frame_tick_q;

endmodule
